aes_round_sequencer: RTL

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_pkg.sv | 99 +++++++++
 rtl/aes_key_step.sv | 32 +++
 rtl/aes_round_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants, FSM state encoding and the combinational round
// primitives (SubBytes, ShiftRows, MixColumns) used by the round sequencer
// and the key-expansion step.
//
// Byte ordering: byte i of a 128-bit block sits at bits [8i+7:8i];
// column c, row r of the AES state is byte 4c+r.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NB = 128;   // state/key/block width in bits
    localparam int AES_NR = 10;    // AES-128 round count
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    // S-box: inverse followed by the affine transform (rotations by 1..4, ^ 0x63).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-expansion step, purely combinational.
//   i_rk      : current round key (word c = bytes 4c..4c+3)
//   i_rcon    : round constant for this step
//   o_next_rk : following round key
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_NB-1:0] i_rk,
    input  logic [BYTE_W-1:0] i_rcon,
    output logic [AES_NB-1:0] o_next_rk
);

    logic [31:0] w_rot;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    // RotWord: new byte r takes old byte (r+1) mod 4 of the last word.
    assign w_rot  = {i_rk[103:96], i_rk[127:104]};
    assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0]) ^ i_rcon};

    assign w_n0 = i_rk[31:0]   ^ w_temp;
    assign w_n1 = i_rk[63:32]  ^ w_n0;
    assign w_n2 = i_rk[95:64]  ^ w_n1;
    assign w_n3 = i_rk[127:96] ^ w_n2;

    assign o_next_rk = {w_n3, w_n2, w_n1, w_n0};

endmodule

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly. Accept-to-out_valid latency is NR cycles.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : plaintext/key present      in_ready  : IDLE, job accepted
//   plaintext    : input block                key       : cipher key
//   out_valid    : ciphertext valid (DONE)    out_ready : consumer takes it
//   ciphertext   : result, stable in DONE
//   round        : current round in ROUND, 0 otherwise
//   o_dbg_state  : FSM state (aes_state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is only asserted in IDLE, out_valid only in DONE; once
// out_valid rises it and ciphertext hold until out_ready is seen. in_valid
// outside IDLE and out_ready outside DONE have no effect. rst overrides both.
// ---------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NB = AES_NB,
    parameter int NR = AES_NR
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NB-1:0] plaintext,
    input  logic [NB-1:0] key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NB-1:0] ciphertext,
    output logic [3:0]    round,
    output logic [1:0]    o_dbg_state
);

    aes_state_e  r_state;
    aes_state_e  w_next_state;
    logic [NB-1:0] r_blk;
    logic [NB-1:0] r_rk;
    logic [7:0]    r_rcon;
    logic [3:0]    r_rcnt;

    logic          w_accept;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_last;
    logic [NB-1:0] w_next_rk;
    logic [NB-1:0] w_sr;
    logic [NB-1:0] w_round_out;

    aes_key_step u_key_step (
        .i_rk      (r_rk),
        .i_rcon    (r_rcon),
        .o_next_rk (w_next_rk)
    );

    assign w_last = (r_rcnt == 4'(NR));
    assign w_sr   = shift_rows(sub_bytes(r_blk));
    // Final round skips MixColumns.
    assign w_round_out = (w_last ? w_sr : mix_columns(w_sr)) ^ w_next_rk;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk  <= '0;
            r_rk   <= '0;
            r_rcon <= 8'h01;
            r_rcnt <= 4'd0;
        end else if (w_accept) begin
            r_blk  <= plaintext ^ key;
            r_rk   <= key;
            r_rcon <= 8'h01;
            r_rcnt <= 4'd1;
        end else if (r_state == ST_ROUND) begin
            r_blk  <= w_round_out;
            r_rk   <= w_next_rk;
            r_rcon <= xtime(r_rcon);
            r_rcnt <= r_rcnt + 4'd1;
        end
    end

    // Handshake outputs are forced low during reset, whatever the state.
    assign in_ready    = w_in_ready && !rst;
    assign out_valid   = w_out_valid && !rst;
    assign ciphertext  = r_blk;
    assign round       = (r_state == ST_ROUND) ? r_rcnt : 4'd0;
    assign o_dbg_state = r_state;

endmodule
